count_pwm_gen: RTL
==================

# count_pwm_gen

Downstream consumer of the 4-bit synchronous up counter's `count` bus. Compares the free-running count against a double-buffered duty value to produce a registered PWM output. Also detects period boundaries (wrap 15→0), counts completed periods, and optionally flags count-sequence violations. The duty value is written by the control side and applied only at a period boundary, so `pwm_out` never glitches mid-period.

## Interface
- `WIDTH`, 4: width of `count_in`; period = 2^WIDTH cycles.
- `PCNT_W`, 8: width of `period_cnt`.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `count_in` in WIDTH: counter value, sampled every cycle.
- `duty_in` in WIDTH+1: requested high-time in cycles, 0..2^WIDTH.
- `duty_wr` in 1: one-cycle strobe; captures `duty_in` into the shadow register.
- `pwm_out` out 1: registered PWM output.
- `wrap_pulse` out 1: one-cycle pulse per detected wrap.
- `duty_ack` out 1: one-cycle pulse when the shadow duty is transferred to the active duty.
- `period_cnt` out PCNT_W: number of wraps since reset, modulo 2^PCNT_W.
- `seq_err` out 1: sticky count-sequence error flag.

## Operation
- Internal state: `prev_count`, `has_prev`, `shadow_duty`, `pending`, `active_duty`.
  - `shadow_duty` and `active_duty` are WIDTH+1 bits.
- `duty_in` values above 2^WIDTH saturate to 2^WIDTH on capture.
- **Boundary** is true in the sample cycle when `count_in == 0` and either of these holds:
  - `has_prev == 0` (first sample after reset), or
  - `prev_count != 0`.
- **Wrap** is true when `has_prev`, `prev_count == 2^WIDTH-1` and `count_in == 0`.
  - A boundary that is not a wrap is a restart, e.g. counter reset mid-period.
- Effective duty this cycle: `shadow_duty` if (boundary and `pending`), else `active_duty`.
- `pwm_out` next value = (`count_in` < effective duty).
  - Duty 0 → output always low.
  - Duty 2^WIDTH → output always high.
- At a boundary with `pending` set:
  - `active_duty` ← `shadow_duty`.
  - `pending` ← 0.
  - `duty_ack` pulses.
- `duty_wr`:
  - Sets `shadow_duty` ← saturated `duty_in` and sets `pending`.
  - Consecutive writes before a boundary overwrite the shadow; only the last one applies.
  - A write in the same cycle as a boundary is not applied at that boundary. The boundary transfers the old shadow (if pending). The new value lands in the shadow with `pending` = 1 and is applied at the next boundary.
- On wrap: `wrap_pulse` pulses and `period_cnt` increments. `period_cnt` rolls over from 2^PCNT_W-1 to 0 with no flag.
- Every cycle: `prev_count` ← `count_in` and `has_prev` ← 1.

## Timing
- Outputs are all registered, with latency 1 cycle from the `count_in` sample to `pwm_out`, `wrap_pulse`, `duty_ack`, `period_cnt` and `seq_err`.
- Reset values: `pwm_out` 0, `wrap_pulse` 0, `duty_ack` 0, `period_cnt` 0, `seq_err` 0.
- Internal state on reset: `active_duty` 0, `shadow_duty` 0, `pending` 0, `has_prev` 0.
- `rst` asserted mid-period:
  - Discards any pending shadow write.
  - Duty returns to 0.
  - The first post-reset sample is never a wrap and never a sequence error.
- `rst` has priority over `duty_wr` in the same cycle.
- Minimum spacing between `duty_wr` strobes: none; a write on every cycle is legal.

## Configuration
- `COUNT_SEQ_CHECK_EN` defined: the sequence checker is compiled in.
  - When `has_prev` is 1, `count_in` != (`prev_count`+1) mod 2^WIDTH, and `count_in` != 0, `seq_err` sets one cycle later.
  - `seq_err` stays set until `rst`.
  - A restart to 0 is not an error.
  - A stalled (repeated) nonzero count is an error.
- Not defined: no checker logic; `seq_err` is tied to 0.

## Test plan
- **Reset then free count:** `rst` high 2 cycles, then `count_in` 0..15 repeating with duty never written → `pwm_out` 0 throughout; `wrap_pulse` once per 16 cycles, one cycle after sampling 0 following 15; `period_cnt` 1, 2, 3….
- **Duty 5 written mid-period:** write when `count_in` = 7 → `duty_ack` one cycle after the next 0 sample; from then `pwm_out` is high for counts 0–4 (5 cycles) and low for counts 5–15 (11 cycles); the current period is unaffected.
- **Boundary collision:** pending duty 3; write duty 12 in the cycle `count_in` = 0 is sampled → that period uses 3; the following period uses 12; `duty_ack` fires at both boundaries.
- **Extremes:** duty 0 → `pwm_out` constantly 0; duty 16 → constantly 1; `duty_in` = 31 → saturated to 16, constantly 1.
- **Mid-run counter reset:** `count_in` 0..9 then 0 → no `wrap_pulse`, `period_cnt` unchanged, pending duty is applied at this boundary; with `COUNT_SEQ_CHECK_EN`, `seq_err` stays 0.
- **Sequence fault** (with `COUNT_SEQ_CHECK_EN`): sequence 4, 5, 5, 6 → `seq_err` rises one cycle after the second 5 is sampled and holds until `rst`; built without the macro → `seq_err` stays 0.

Source files
------------

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: registered PWM generator driven by an external free-running
// up counter. Duty is double-buffered and only applied at a period boundary.
//
// Parameters:
//   WIDTH   - width of count_in; period is 2^WIDTH cycles
//   PCNT_W  - width of period_cnt
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - synchronous active-high reset
//   count_in   - counter value, sampled every cycle
//   duty_in    - requested high time in cycles, 0..2^WIDTH (saturated above)
//   duty_wr    - one-cycle strobe capturing duty_in into the shadow register
//   pwm_out    - registered PWM output
//   wrap_pulse - one-cycle pulse per detected wrap (max -> 0)
//   duty_ack   - one-cycle pulse when shadow duty becomes active
//   period_cnt - wraps since reset, modulo 2^PCNT_W
//   seq_err    - sticky count-sequence error flag
// Build option:
//   COUNT_SEQ_CHECK_EN - compiles in the count-sequence checker; when
//   undefined, seq_err is tied low.

module count_pwm_gen #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count_in,
    input  logic [WIDTH:0]    duty_in,
    input  logic              duty_wr,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic              duty_ack,
    output logic [PCNT_W-1:0] period_cnt,
    output logic              seq_err
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    logic [WIDTH-1:0] prev_count;
    logic             has_prev;
    logic [WIDTH:0]   shadow_duty;
    logic             pending;
    logic [WIDTH:0]   active_duty;

    logic             cnt_zero;
    logic             boundary;
    logic             wrap;
    logic             apply;
    logic [WIDTH:0]   eff_duty;
    logic [WIDTH:0]   duty_sat;

    assign cnt_zero = (count_in == '0);

    // A boundary is any arrival at zero: the first sample after reset,
    // a genuine wrap, or a restart of the upstream counter mid-period.
    assign boundary = cnt_zero && (!has_prev || (prev_count != '0));
    assign wrap     = cnt_zero && has_prev && (prev_count == CNT_MAX);
    assign apply    = boundary && pending;

    // The pending shadow takes effect in the very cycle of the boundary,
    // so the first cycle of the new period already uses the new duty.
    assign eff_duty = apply ? shadow_duty : active_duty;
    assign duty_sat = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_count  <= '0;
            has_prev    <= 1'b0;
            shadow_duty <= '0;
            pending     <= 1'b0;
            active_duty <= '0;
            pwm_out     <= 1'b0;
            wrap_pulse  <= 1'b0;
            duty_ack    <= 1'b0;
            period_cnt  <= '0;
        end else begin
            pwm_out    <= ({1'b0, count_in} < eff_duty);
            wrap_pulse <= wrap;
            duty_ack   <= apply;
            prev_count <= count_in;
            has_prev   <= 1'b1;

            if (wrap) begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (apply) begin
                active_duty <= shadow_duty;
                pending     <= 1'b0;
            end

            // A write colliding with a boundary lands after the transfer
            // above, so it stays pending for the next boundary.
            if (duty_wr) begin
                shadow_duty <= duty_sat;
                pending     <= 1'b1;
            end
        end
    end

`ifdef COUNT_SEQ_CHECK_EN
    logic [WIDTH-1:0] next_exp;
    logic             seq_bad;

    assign next_exp = prev_count + 1'b1;
    // Restarts to zero are legal; stalls and skips to nonzero are not.
    assign seq_bad  = has_prev && !cnt_zero && (count_in != next_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err <= 1'b0;
        end else if (seq_bad) begin
            seq_err <= 1'b1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule
